test_mon_sopc: RTL

- Parametrised on-bench supervisor for openmips_min_sopc program tests; successor to per-test fixed-delay benches.
- Watches instruction-fetch port (ce/pc/inst) and data-bus writes and decides pass/fail/timeout/halt from the running program.
- Counts cycles and retired fetches, then raises sticky result flags for the bench to sample and $finish on.
- Synthesisable, so the same block also fits FPGA bring-up.

---
 rtl/test_mon_pkg.sv | 23 ++
 rtl/test_mon_stuck_det.sv | 57 +++++
 rtl/test_mon_sopc.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/test_mon_pkg.sv
// Shared definitions for the openmips_min_sopc test supervisor:
// FSM state encodings and the default signature address / pass value.
package test_mon_pkg;

   localparam int ST_W = 3;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE = 3'd0,
      ST_RUN  = 3'd1,
      ST_PASS = 3'd2,
      ST_FAIL = 3'd3,
      ST_TMO  = 3'd4
   } state_t;

   localparam logic [31:0] DEF_PASS_VAL = 32'h600D_600D;
   localparam logic [31:0] DEF_SIG_ADDR = 32'h0000_0100;

   // A terminal state holds until reset.
   function automatic logic is_terminal(state_t s);
      return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TMO);
   endfunction

endpackage

// File: rtl/test_mon_stuck_det.sv
// Halt detector: flags a program spinning on a branch-to-self plus delay
// slot, i.e. STUCK_REP consecutive fetches whose pc equals the pc fetched
// two fetches earlier. Fetches with ce=0 leave the repeat count untouched.
module test_mon_stuck_det #(
   parameter int AW        = 32,
   parameter int STUCK_REP = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          en,
   input  logic          ce,
   input  logic [AW-1:0] pc,
   output logic          stuck
);

   localparam int RW = $clog2(STUCK_REP + 1);

   logic [AW-1:0] hist1_reg;   // previous fetched pc
   logic [AW-1:0] hist2_reg;   // pc fetched two fetches ago
   logic [1:0]    fill_reg;    // number of valid history entries (0..2)
   logic [RW-1:0] rep_reg;
   logic [RW-1:0] rep_next;
   logic          match;

   assign match = (fill_reg == 2'd2) && (pc == hist2_reg);

   // Next repeat count: bump on a period-2 match, clear on any other fetch.
   always_comb begin
      rep_next = rep_reg;
      if (en && ce) begin
         if (!match)
            rep_next = '0;
         else if (rep_reg != RW'(STUCK_REP))
            rep_next = rep_reg + 1'b1;
      end
   end

   // Stuck is combinational so the FSM decides in the same cycle as the fetch.
   assign stuck = en && ce && (rep_next == RW'(STUCK_REP));

   // Shift the pc history and commit the repeat count on every enabled fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist1_reg <= '0;
         hist2_reg <= '0;
         fill_reg  <= '0;
         rep_reg   <= '0;
      end else if (en && ce) begin
         hist1_reg <= pc;
         hist2_reg <= hist1_reg;
         if (fill_reg != 2'd2)
            fill_reg <= fill_reg + 2'd1;
         rep_reg   <= rep_next;
      end
   end

endmodule

// File: rtl/test_mon_sopc.sv
// Program-test supervisor for openmips_min_sopc. Watches the fetch port and
// data writes, decides pass / fail / timeout / halt and raises sticky flags.
// Optional fetch trace (last four pc/inst pairs) under TEST_MON_TRACE_EN.
module test_mon_sopc
   import test_mon_pkg::*;
#(
   parameter int            AW          = 32,
   parameter int            DW          = 32,
   parameter int            TIMEOUT_CYC = 1000,
   parameter logic [AW-1:0] SIG_ADDR    = AW'(DEF_SIG_ADDR),
   parameter logic [DW-1:0] PASS_VAL    = DW'(DEF_PASS_VAL),
   parameter int            STUCK_REP   = 8,
   parameter int            CW          = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            ce,
   input  logic [AW-1:0]   pc,
   input  logic [31:0]     inst,
   input  logic            mem_we,
   input  logic [AW-1:0]   mem_addr,
   input  logic [DW-1:0]   mem_wdata,
   output logic            done,
   output logic            pass,
   output logic            fail,
   output logic            timeout,
   output logic [2:0]      state,
   output logic [CW-1:0]   cyc_cnt,
   output logic [CW-1:0]   fetch_cnt,
   output logic [DW-1:0]   sig_val
`ifdef TEST_MON_TRACE_EN
   ,
   output logic [4*AW-1:0] trace_pc,
   output logic [4*32-1:0] trace_inst
`endif
);

   state_t state_reg;
   state_t state_next;
   logic   active;
   logic   sig_hit;
   logic   stuck;

   // The IDLE cycle that sees the first fetch already belongs to the run.
   assign active  = (state_reg == ST_RUN) || ((state_reg == ST_IDLE) && ce);
   assign sig_hit = mem_we && (mem_addr == SIG_ADDR);
   assign state   = state_reg;

   test_mon_stuck_det #(
      .AW        (AW),
      .STUCK_REP (STUCK_REP)
   ) u_stuck (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (active),
      .ce      (ce),
      .pc      (pc),
      .stuck   (stuck)
   );

   // Decision logic: signature write beats halt, halt beats timeout.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (ce) state_next = ST_RUN;
         ST_RUN: begin
            if (sig_hit)
               state_next = (mem_wdata == PASS_VAL) ? ST_PASS : ST_FAIL;
            else if (stuck)
               state_next = (sig_val == PASS_VAL) ? ST_PASS : ST_FAIL;
            else if (cyc_cnt == CW'(TIMEOUT_CYC))
               state_next = ST_TMO;
         end
         default: state_next = state_reg;
      endcase
   end

   // FSM register with result flags registered from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state_reg <= state_next;
         done      <= is_terminal(state_next);
         pass      <= (state_next == ST_PASS);
         fail      <= (state_next == ST_FAIL);
         timeout   <= (state_next == ST_TMO);
      end
   end

   // Saturating run-cycle and fetch counters; frozen outside the run.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc_cnt   <= '0;
         fetch_cnt <= '0;
      end else if (active) begin
         if (cyc_cnt != '1)
            cyc_cnt <= cyc_cnt + 1'b1;
         if (ce && (fetch_cnt != '1))
            fetch_cnt <= fetch_cnt + 1'b1;
      end
   end

   // Signature capture, allowed until a result has been decided.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         sig_val <= '0;
      else if (sig_hit && !is_terminal(state_reg))
         sig_val <= mem_wdata;
   end

`ifdef TEST_MON_TRACE_EN
   // Four-deep fetch trace; slice 0 is the newest fetch.
   for (genvar gi = 0; gi < 4; gi++) begin : g_trace
      logic [AW-1:0] pc_q;
      logic [31:0]   inst_q;
      if (gi == 0) begin : g_head
         // Newest slot loads straight from the fetch port.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               pc_q   <= '0;
               inst_q <= '0;
            end else if (active && ce) begin
               pc_q   <= pc;
               inst_q <= inst;
            end
         end
      end else begin : g_tail
         // Older slots shift from their younger neighbour.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               pc_q   <= '0;
               inst_q <= '0;
            end else if (active && ce) begin
               pc_q   <= g_trace[gi-1].pc_q;
               inst_q <= g_trace[gi-1].inst_q;
            end
         end
      end
      assign trace_pc[gi*AW +: AW]   = pc_q;
      assign trace_inst[gi*32 +: 32] = inst_q;
   end
`else
   // Without the trace the instruction word has no consumer.
   logic unused_inst;
   assign unused_inst = ^inst;
`endif

endmodule
